// File: rtl/counter_sequencer_pkg.sv
// counter_sequencer_pkg
//   Shared definitions for the counter run-control block: run-state encoding,
//   default datapath width and terminal count, and a helper that sizes the
//   prescaler register from the PRESCALE parameter.
package counter_sequencer_pkg;

    localparam int SEQ_WIDTH         = 10;
    localparam int SEQ_DEFAULT_LIMIT = 999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // Bits needed to count 0..prescale-1; a prescale of 1 still gets one bit.
    function automatic int presc_width(input int prescale);
        if (prescale > 1) begin
            return $clog2(prescale);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if
//   Control/status bundle between the board-level controller (master) and the
//   counter sequencer (slave).
//   master drives : cfg_valid, cfg_limit, cfg_periodic, start, stop, hold
//   slave drives  : cfg_ready, q, wrap, busy, done
interface counter_sequencer_if
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_limit;
    logic             cfg_periodic;
    logic             start;
    logic             stop;
    logic             hold;
    logic [WIDTH-1:0] q;
    logic             wrap;
    logic             busy;
    logic             done;

    modport master (
        output cfg_valid, cfg_limit, cfg_periodic, start, stop, hold,
        input  cfg_ready, q, wrap, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_limit, cfg_periodic, start, stop, hold,
        output cfg_ready, q, wrap, busy, done
    );
endinterface

// File: rtl/counter_sequencer_core.sv
// count_core
//   WIDTH-bit up counter that returns to zero after reaching limit.
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset (q -> 0)
//   clr      in   synchronous clear to zero (wins over en)
//   en       in   advance one step this cycle
//   limit    in   terminal count
//   q        out  registered count
//   at_limit out  combinational q == limit
module count_core
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             at_limit
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // The equality test (not an overflow) decides the wrap, so an all-ones
    // limit behaves like any other.
    assign at_limit = (q_q == limit);
    assign q        = q_q;

    // Next count: clear, step/wrap, or hold.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            if (at_limit) begin
                q_d = '0;
            end else begin
                q_d = q_q + ONE;
            end
        end else begin
            q_d = q_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end
endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Run control for a WIDTH-bit counter: accepts a terminal count and mode over
//   a valid/ready handshake, then runs, pauses, stops and restarts the count.
//   Emits a one-cycle wrap pulse at each terminal step and a sticky done flag
//   when a one-shot run completes.
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-low reset
//   bus    slave modport: cfg_valid/cfg_ready/cfg_limit/cfg_periodic,
//          start/stop/hold controls; q/wrap/busy/done status
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH         = SEQ_WIDTH,
    parameter int DEFAULT_LIMIT = SEQ_DEFAULT_LIMIT,
    parameter int PRESCALE      = 1
) (
    input  logic                clk,
    input  logic                reset,
    counter_sequencer_if.slave  bus
);
    localparam int               PW         = presc_width(PRESCALE);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] LIMIT_RST  = WIDTH'(DEFAULT_LIMIT);

    seq_state_e       state_q;
    logic [WIDTH-1:0] limit_q;
    logic             periodic_q;
    logic [PW-1:0]    presc_q;
    logic             wrap_q;
    logic             busy_q;
    logic             done_q;
    logic             cfg_ready_q;

    logic             cfg_fire_s;
    logic             core_clr_s;
    logic             core_en_s;
    logic             at_limit_s;
    logic [WIDTH-1:0] q_s;

    assign cfg_fire_s = bus.cfg_valid && cfg_ready_q;

    // Counter datapath controls: clear on stop or run entry; step only on a
    // prescaler tick in RUN, except the final one-shot step where q holds.
    always_comb begin
        core_clr_s = 1'b0;
        core_en_s  = 1'b0;
        if (bus.stop) begin
            core_clr_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: core_clr_s = bus.start;
                ST_RUN:           core_en_s  = !bus.hold && (presc_q == PRESC_LAST)
                                               && (periodic_q || !at_limit_s);
                default:          core_en_s  = 1'b0;
            endcase
        end
    end

    count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .clr      (core_clr_s),
        .en       (core_en_s),
        .limit    (limit_q),
        .q        (q_s),
        .at_limit (at_limit_s)
    );

    // Run-state FSM with config capture, prescaler and registered status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            limit_q     <= LIMIT_RST;
            periodic_q  <= 1'b1;
            presc_q     <= '0;
            wrap_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            wrap_q <= 1'b0;
            // Config is only ever ready outside RUN/PAUSE, so it never changes
            // the limit of a run in progress. A start in the same cycle
            // therefore runs with the new values.
            if (cfg_fire_s) begin
                limit_q    <= bus.cfg_limit;
                periodic_q <= bus.cfg_periodic;
                done_q     <= 1'b0;
            end
            if (bus.stop) begin
                state_q     <= ST_IDLE;
                presc_q     <= '0;
                busy_q      <= 1'b0;
                done_q      <= 1'b0;
                cfg_ready_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (bus.start) begin
                            state_q     <= ST_RUN;
                            presc_q     <= '0;
                            busy_q      <= 1'b1;
                            done_q      <= 1'b0;
                            cfg_ready_q <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (bus.hold) begin
                            // Prescaler phase is kept so the resume lands on the same beat.
                            state_q <= ST_PAUSE;
                        end else if (presc_q == PRESC_LAST) begin
                            presc_q <= '0;
                            if (at_limit_s) begin
                                wrap_q <= 1'b1;
                                if (!periodic_q) begin
                                    state_q     <= ST_DONE;
                                    busy_q      <= 1'b0;
                                    done_q      <= 1'b1;
                                    cfg_ready_q <= 1'b1;
                                end
                            end
                        end else begin
                            presc_q <= presc_q + PRESC_ONE;
                        end
                    end
                    ST_PAUSE: begin
                        if (!bus.hold) begin
                            state_q <= ST_RUN;
                        end
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        presc_q     <= '0;
                        busy_q      <= 1'b0;
                        cfg_ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.q         = q_s;
    assign bus.wrap      = wrap_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cfg_ready = cfg_ready_q;

endmodule
